// File: rtl/muldiv_seq_pkg.sv
// Shared cpu definitions for the iterative multiply/divide unit.
// Function codes, sequencer states and default data width.
package muldiv_seq_pkg;
  localparam int DATA_W = 16;

  localparam logic [3:0] FC_MUL = 4'b0100;
  localparam logic [3:0] FC_DIV = 4'b0101;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } md_state_e;
endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate of a word pair, either as
// two independent words or as one joined double-width value.
module muldiv_sign_fix #(
  parameter int WIDTH = 16
) (
  input  logic             joint,
  input  logic             neg_hi,
  input  logic             neg_lo,
  input  logic [WIDTH-1:0] x_hi,
  input  logic [WIDTH-1:0] x_lo,
  output logic [WIDTH-1:0] y_hi,
  output logic [WIDTH-1:0] y_lo
);
  logic [2*WIDTH-1:0] wide;

  always_comb begin
    wide = {x_hi, x_lo};
    y_hi = x_hi;
    y_lo = x_lo;
    if (joint) begin
      if (neg_lo) wide = -wide;
      y_hi = wide[2*WIDTH-1:WIDTH];
      y_lo = wide[WIDTH-1:0];
    end else begin
      if (neg_hi) y_hi = -x_hi;
      if (neg_lo) y_lo = -x_lo;
    end
  end
endmodule

// File: rtl/muldiv_seq.sv
// Iterative signed MUL/DIV sequencer with pipeline stall.
// Optional MULDIV_EARLY_OUT_EN: MUL exits once multiplier bits run out.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       fc,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  md_state_e state, state_nxt;

  logic [CW-1:0]      count;
  logic               is_mul, sa, sb, dbz_pend;
  logic [2*WIDTH-1:0] acc, acc_nxt, mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH:0]     abs_a, abs_b, trial;
  logic [WIDTH-1:0]   diff, fix_hi, fix_lo;
  logic               accept, last;

  assign accept = (state == IDLE) & start & ~rst &
                  ((fc == FC_MUL) | (fc == FC_DIV));
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign stall  = accept | (state == CALC);

  muldiv_sign_fix #(.WIDTH(WIDTH + 1)) u_abs (
    .joint (1'b0),
    .neg_hi(op_a[WIDTH-1]),
    .neg_lo(op_b[WIDTH-1]),
    .x_hi  ({op_a[WIDTH-1], op_a}),
    .x_lo  ({op_b[WIDTH-1], op_b}),
    .y_hi  (abs_a),
    .y_lo  (abs_b)
  );

  // DIV keeps {remainder, dividend} in acc; MUL accumulates the product
  always_comb begin
    trial   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff    = WIDTH'(trial - mcand[WIDTH:0]);
    acc_nxt = acc;
    if (is_mul) begin
      if (mplier[0]) acc_nxt = acc + mcand;
    end else if (trial >= mcand[WIDTH:0]) begin
      acc_nxt = {diff, acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_res (
    .joint (is_mul),
    .neg_hi(sa),
    .neg_lo(sa ^ sb),
    .x_hi  (acc_nxt[2*WIDTH-1:WIDTH]),
    .x_lo  (acc_nxt[WIDTH-1:0]),
    .y_hi  (fix_hi),
    .y_lo  (fix_lo)
  );

  assign last = (count == CW'(WIDTH - 1)) |
                (EARLY & is_mul & (mplier[WIDTH-1:1] == '0));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = CALC;
      CALC: if (last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      is_mul      <= 1'b0;
      sa          <= 1'b0;
      sb          <= 1'b0;
      dbz_pend    <= 1'b0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      res_lo      <= '0;
      res_hi      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        is_mul      <= (fc == FC_MUL);
        sa          <= op_a[WIDTH-1];
        sb          <= op_b[WIDTH-1];
        dbz_pend    <= (fc == FC_DIV) & (op_b == '0);
        div_by_zero <= 1'b0;
        count       <= '0;
        mplier      <= abs_b[WIDTH-1:0];
        if (fc == FC_MUL) begin
          mcand <= {{(WIDTH-1){1'b0}}, abs_a};
          acc   <= '0;
        end else begin
          mcand <= {{(WIDTH-1){1'b0}}, abs_b};
          acc   <= {{WIDTH{1'b0}}, abs_a[WIDTH-1:0]};
        end
      end else if (state == CALC) begin
        acc    <= acc_nxt;
        mplier <= mplier >> 1;
        count  <= count + 1'b1;
        if (is_mul) mcand <= mcand << 1;
        if (last) begin
          res_hi      <= fix_hi;
          res_lo      <= dbz_pend ? '1 : fix_lo;
          div_by_zero <= dbz_pend;
        end
      end
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed plus random bench for muldiv_seq against an arithmetic
// reference model; latency expectation follows MULDIV_EARLY_OUT_EN.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  fc;
  logic [15:0] op_a, op_b;
  logic        busy, done, stall, div_by_zero;
  logic [15:0] res_lo, res_hi;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .fc         (fc),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .stall      (stall),
    .res_lo     (res_lo),
    .res_hi     (res_hi),
    .div_by_zero(div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model(input logic [3:0] f, input logic [15:0] a,
                       input logic [15:0] b, output logic [15:0] hi,
                       output logic [15:0] lo, output logic dz,
                       output int lat);
    int     ai, bi, q, r, mb;
    longint p;
    logic [63:0] pv;
    ai  = int'($signed(a));
    bi  = int'($signed(b));
    dz  = 1'b0;
    lat = 16;
    if (f == FC_MUL) begin
      p  = longint'(ai) * longint'(bi);
      pv = p;
      hi = pv[31:16];
      lo = pv[15:0];
      mb = (bi < 0) ? -bi : bi;
`ifdef MULDIV_EARLY_OUT_EN
      lat = 1;
      for (int i = 0; i < 16; i++) if (mb[i]) lat = i + 1;
`endif
    end else if (b == 16'h0) begin
      hi = a;
      lo = 16'hFFFF;
      dz = 1'b1;
    end else begin
      q  = ai / bi;
      r  = ai % bi;
      hi = r[15:0];
      lo = q[15:0];
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] f,
                        input logic [15:0] a, input logic [15:0] b,
                        input bit poke);
    logic [15:0] ehi, elo;
    logic        edz;
    int          elat, n, st;
    model(f, a, b, ehi, elo, edz, elat);
    @(negedge clk);
    start = 1'b1;
    fc    = f;
    op_a  = a;
    op_b  = b;
    #1;
    check({tag, ".stall_acc"}, 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = 16'($urandom);
    op_b  = 16'($urandom);
    check({tag, ".dbz_clr"}, 32'(div_by_zero), 32'd0);
    n  = 0;
    st = 0;
    while (!done && n < 40) begin
      if (stall) st++;
      if (poke && n == 4) begin
        start = 1'b1;
        fc    = (f == FC_MUL) ? FC_DIV : FC_MUL;
      end
      if (poke && n == 6) start = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".latency"}, 32'(n), 32'(elat));
    check({tag, ".stall_cnt"}, 32'(st), 32'(elat));
    check({tag, ".stall_done"}, 32'(stall), 32'd0);
    check({tag, ".hi"}, 32'(res_hi), 32'(ehi));
    check({tag, ".lo"}, 32'(res_lo), 32'(elo));
    check({tag, ".dbz"}, 32'(div_by_zero), 32'(edz));
    @(posedge clk);
    #1;
    check({tag, ".idle"}, {30'd0, busy, done}, 32'd0);
    check({tag, ".hold"}, {res_hi, res_lo}, {ehi, elo});
  endtask

  initial begin
    logic [3:0]  rf;
    logic [15:0] ra, rb;
    rst   = 1'b1;
    start = 1'b0;
    fc    = 4'h0;
    op_a  = 16'h0;
    op_b  = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.ctl", {29'd0, busy, done, stall}, 32'd0);
    check("reset.res", {res_hi, res_lo}, 32'd0);
    check("reset.dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;

    run_op("mul_3x-5", FC_MUL, 16'd3, 16'hFFFB, 1'b0);
    run_op("div_-7/2", FC_DIV, 16'hFFF9, 16'd2, 1'b0);
    run_op("div_100/0", FC_DIV, 16'h0064, 16'h0000, 1'b0);
    run_op("div_min/-1", FC_DIV, 16'h8000, 16'hFFFF, 1'b0);
    run_op("mul_min2", FC_MUL, 16'h8000, 16'h8000, 1'b0);
    run_op("mul_0xb", FC_MUL, 16'h0000, 16'h1234, 1'b0);
    run_op("mul_bx0", FC_MUL, 16'hBEEF, 16'h0000, 1'b0);
    run_op("div_neg0", FC_DIV, 16'hFF9C, 16'h0000, 1'b0);

    @(negedge clk);
    start = 1'b1;
    fc    = 4'b0111;
    op_a  = 16'd9;
    op_b  = 16'd9;
    #1;
    check("badfc.stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    check("badfc.busy", 32'(busy), 32'd0);
    start = 1'b0;

    run_op("poke_div", FC_DIV, 16'd1000, 16'd7, 1'b1);
    run_op("poke_mul", FC_MUL, 16'hF00D, 16'h8001, 1'b1);

    run_op("pre_rst_dz", FC_DIV, 16'h0042, 16'h0000, 1'b0);
    @(negedge clk);
    start = 1'b1;
    fc    = FC_MUL;
    op_a  = 16'd7;
    op_b  = 16'h8009;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst.ctl", {29'd0, busy, done, stall}, 32'd0);
    check("midrst.res", {res_hi, res_lo}, 32'd0);
    check("midrst.dbz", 32'(div_by_zero), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("midrst.quiet", {15'd0, busy, res_hi}, 32'd0);
    run_op("mul_2x2", FC_MUL, 16'd2, 16'd2, 1'b0);

    run_op("mul_5x1", FC_MUL, 16'd5, 16'd1, 1'b0);
    run_op("mul_5xmin", FC_MUL, 16'd5, 16'h8000, 1'b0);

    for (int k = 0; k < 24; k++) begin
      rf = ($urandom_range(0, 1) == 0) ? FC_MUL : FC_DIV;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 7) == 0) rb = 16'h0;
      if ($urandom_range(0, 3) == 0) rb = 16'($urandom_range(0, 15));
      run_op($sformatf("rnd%0d", k), rf, ra, rb, 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
